mission_sequencer: RTL and testbench
====================================

MISSION_SEQUENCER -- requirements
Module: mission_sequencer

Interface
REQ-001 The block SHALL have parameter GAP_CYC, default 10, meaning the number of all-disabled cycles inserted between any two Core phases.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1000, meaning the maximum cycles allowed in one tracking or u-turn phase before fault.
REQ-003 The block SHALL have parameter TW, default 16, meaning the phase-timer width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins a mission when sampled high in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: returns the block to IDLE from any state.
REQ-008 The block SHALL have port clear, input, 1 bit: leaves DONE or FAULT.
REQ-009 The block SHALL have port leg_target, input, 4 bits: the number of tracking legs in the mission, latched at start.
REQ-010 The block SHALL have port end_of_track, input, 1 bit: from Core, meaning the tracking leg is complete.
REQ-011 The block SHALL have port uturn_finished, input, 1 bit: from Core, meaning the u-turn is complete.
REQ-012 The block SHALL have port en_tracking, output, 1 bit: tracking enable to Core.
REQ-013 The block SHALL have port en_uturn, output, 1 bit: u-turn enable to Core.
REQ-014 The block SHALL have port legs_done, output, 4 bits: the count of completed legs.
REQ-015 The block SHALL have ports busy, done and fault, each output, 1 bit: the mission status flags.

Function
REQ-016 The block SHALL have states IDLE, TRACK, GAP_U, UTURN, GAP_T, DONE and FAULT; all outputs are registered, Moore-style.
REQ-017 In IDLE, start=1 with leg_target≠0 SHALL latch the target, clear legs_done, and enter TRACK; en_tracking=1 from the next edge (1-cycle latency).
REQ-018 In IDLE, start=1 with leg_target=0 SHALL be ignored; start SHALL be ignored in all other states.
REQ-019 In TRACK, end_of_track=1 SHALL increment legs_done; the block then enters DONE if the new count equals the target, else GAP_U.
REQ-020 In GAP_U, after exactly GAP_CYC cycles, the block SHALL enter UTURN with en_uturn=1.
REQ-021 In UTURN, uturn_finished=1 SHALL enter GAP_T; after GAP_CYC cycles, the block SHALL enter TRACK.
REQ-022 In GAP_U and GAP_T, en_tracking and en_uturn SHALL both be 0, and end_of_track/uturn_finished SHALL be ignored.
REQ-023 en_tracking and en_uturn SHALL never be 1 in the same cycle.
REQ-024 The phase timer SHALL clear on entry to TRACK or UTURN, count each cycle, and saturate at 2^TW-1.
REQ-025 When the timer reaches TIMEOUT_CYC, the block SHALL enter FAULT: fault=1, both enables 0.
REQ-026 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-027 abort=1 SHALL force IDLE on the next edge from any state, dominating all other events; legs_done is held, not cleared.
REQ-028 In DONE and FAULT, the block SHALL hold until clear=1, then enter IDLE; clear SHALL be ignored elsewhere.
REQ-029 busy SHALL be 1 in TRACK, GAP_U, UTURN and GAP_T; done=1 only in DONE.
REQ-030 legs_done SHALL be 4 bits, never wrapping, because the target is ≤15.

Reset
REQ-031 When rst=0, the block SHALL asynchronously enter IDLE, with all outputs 0, timer 0 and latched target 0.
REQ-032 Reset asserted mid-mission SHALL drop both enables within the same cycle.

Structure
REQ-033 The state enum, GAP_CYC/TIMEOUT_CYC defaults and the 4-bit leg width SHALL live in the shared package mission_pkg.
REQ-034 The timer SHALL be a sub-module named phase_timer (clear, enable, saturating count, and a terminal-count compare for GAP and TIMEOUT).

Verification (GAP_CYC=5, TIMEOUT_CYC=50)
REQ-035 The bench SHALL cover: target=2; start; end_of_track at +20 → GAP_U 5 cycles → UTURN; uturn_finished → 5 gap cycles → TRACK; end_of_track → DONE, legs_done=2, done=1.
REQ-036 The bench SHALL cover: target=1; start; end_of_track → DONE directly with no u-turn; clear → IDLE, done=0.
REQ-037 The bench SHALL cover: target=3; no end_of_track for 50 cycles → FAULT, fault=1, enables 0; clear → IDLE.
REQ-038 The bench SHALL cover: end_of_track on the same cycle the timer hits 50 → GAP_U, not FAULT.
REQ-039 The bench SHALL cover: abort during UTURN → IDLE next edge, en_uturn=0, legs_done retained; start with target=0 → stays IDLE.
REQ-040 The bench SHALL cover: rst pulled low mid-TRACK → en_tracking=0 immediately; a checker asserts no cycle has both enables high.

Source files
------------

// File: rtl/mission_pkg.sv
// Shared types and defaults for the mission sequencer: FSM state encoding,
// leg-count width and the default phase lengths.
package mission_pkg;

  localparam int GAP_CYC_DEF     = 10;
  localparam int TIMEOUT_CYC_DEF = 1000;
  localparam int LEG_W           = 4;

  typedef logic [LEG_W-1:0] leg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRACK,
    ST_GAP_U,
    ST_UTURN,
    ST_GAP_T,
    ST_DONE,
    ST_FAULT
  } state_t;

  function automatic logic is_busy(input state_t s);
    return s inside {ST_TRACK, ST_GAP_U, ST_UTURN, ST_GAP_T};
  endfunction

  function automatic logic is_gap(input state_t s);
    return s inside {ST_GAP_U, ST_GAP_T};
  endfunction

endpackage

// File: rtl/mission_sequencer_if.sv
// Control/status bundle between a mission supervisor (master) and the
// sequencer (slave); Core handshakes ride in the same bundle.
interface mission_sequencer_if;
  import mission_pkg::*;

  logic start;
  logic abort;
  logic clear;
  leg_t leg_target;
  logic end_of_track;
  logic uturn_finished;
  logic en_tracking;
  logic en_uturn;
  leg_t legs_done;
  logic busy;
  logic done;
  logic fault;

  modport master (
    output start, abort, clear, leg_target, end_of_track, uturn_finished,
    input  en_tracking, en_uturn, legs_done, busy, done, fault
  );

  modport slave (
    input  start, abort, clear, leg_target, end_of_track, uturn_finished,
    output en_tracking, en_uturn, legs_done, busy, done, fault
  );

endinterface

// File: rtl/phase_timer.sv
// Saturating phase timer with synchronous clear and a terminal-count flag that
// is high during the limit-th counted cycle of a phase.
module phase_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] limit,
  output logic          tc
);

  localparam logic [TW-1:0] CNT_MAX = '1;

  logic [TW-1:0] count_q, count_d;
  logic [TW:0]   count_p1;

  // NOTE: every signal written here gets its default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Compare one ahead so tc marks the last cycle of a limit-long phase.
  assign count_p1 = {1'b0, count_q} + 1'b1;
  assign tc       = (count_p1 >= {1'b0, limit});

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mission_sequencer.sv
// Mission sequencer: alternates Core tracking legs and u-turns separated by
// all-disabled gaps, with per-phase timeout, abort and registered Moore outputs.
module mission_sequencer
  import mission_pkg::*;
#(
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TW          = 16
) (
  input logic                clk,
  input logic                rst,
  mission_sequencer_if.slave bus
);

  localparam logic [TW-1:0] GAP_LIM     = TW'(GAP_CYC);
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYC);
  localparam leg_t          LEG_MAX     = '1;

  state_t state_q, state_d;
  leg_t   target_q, target_d;
  leg_t   legs_q, legs_d, legs_inc;

  logic en_tracking_q, en_tracking_d;
  logic en_uturn_q, en_uturn_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fault_q, fault_d;

  logic          timer_clr, timer_en, timer_tc;
  logic [TW-1:0] timer_limit;

  assign legs_inc = (legs_q == LEG_MAX) ? legs_q : legs_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    legs_d   = legs_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.leg_target != '0)) begin
          target_d = bus.leg_target;
          legs_d   = '0;
          state_d  = ST_TRACK;
        end
      end
      ST_TRACK: begin
        // Completion is checked before timeout so it wins a same-cycle tie.
        if (bus.end_of_track) begin
          legs_d  = legs_inc;
          state_d = (legs_inc == target_q) ? ST_DONE : ST_GAP_U;
        end else if (timer_tc) begin
          state_d = ST_FAULT;
        end
      end
      ST_GAP_U: if (timer_tc) state_d = ST_UTURN;
      ST_UTURN: begin
        if (bus.uturn_finished) begin
          state_d = ST_GAP_T;
        end else if (timer_tc) begin
          state_d = ST_FAULT;
        end
      end
      ST_GAP_T: if (timer_tc) state_d = ST_TRACK;
      ST_DONE, ST_FAULT: if (bus.clear) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle leg completion.
    if (bus.abort) begin
      state_d  = ST_IDLE;
      target_d = target_q;
      legs_d   = legs_q;
    end
  end

  always_comb begin
    timer_clr   = (state_d != state_q);
    timer_en    = is_busy(state_q);
    timer_limit = is_gap(state_q) ? GAP_LIM : TIMEOUT_LIM;
  end

  phase_timer #(.TW(TW)) u_phase_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .en    (timer_en),
    .limit (timer_limit),
    .tc    (timer_tc)
  );

  // Outputs are decoded from the next state and registered, so they track state_q.
  always_comb begin
    en_tracking_d = (state_d == ST_TRACK);
    en_uturn_d    = (state_d == ST_UTURN);
    busy_d        = is_busy(state_d);
    done_d        = (state_d == ST_DONE);
    fault_d       = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      legs_q        <= '0;
      en_tracking_q <= 1'b0;
      en_uturn_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      legs_q        <= legs_d;
      en_tracking_q <= en_tracking_d;
      en_uturn_q    <= en_uturn_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.en_tracking = en_tracking_q;
  assign bus.en_uturn    = en_uturn_q;
  assign bus.legs_done   = legs_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_mission_sequencer.sv
// Self-checking bench for mission_sequencer with GAP_CYC=5, TIMEOUT_CYC=50:
// vector table for short cases, hand sequences for the multi-cycle corners.
module tb_mission_sequencer;
  import mission_pkg::*;

  localparam int GAP = 5;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mission_sequencer_if bus();

  mission_sequencer #(
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TO),
    .TW          (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       en_t;
    logic       en_u;
    logic [3:0] legs;
    logic       busy;
    logic       done;
    logic       fault;
  } out_t;

  typedef struct {
    logic       start;
    logic       abort;
    logic       clear;
    logic [3:0] tgt;
    logic       eot;
    logic       uf;
    out_t       exp;
    string      name;
  } vec_t;

  typedef struct {
    out_t  exp;
    string name;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic out_t mk(input logic et, input logic eu, input int l,
                              input logic b, input logic d, input logic f);
    out_t o;
    o.en_t = et; o.en_u = eu; o.legs = 4'(l);
    o.busy = b;  o.done = d;  o.fault = f;
    return o;
  endfunction

  function automatic out_t o_idle(input int l); return mk(0, 0, l, 0, 0, 0); endfunction
  function automatic out_t o_trk (input int l); return mk(1, 0, l, 1, 0, 0); endfunction
  function automatic out_t o_gap (input int l); return mk(0, 0, l, 1, 0, 0); endfunction
  function automatic out_t o_ut  (input int l); return mk(0, 1, l, 1, 0, 0); endfunction
  function automatic out_t o_done(input int l); return mk(0, 0, l, 0, 1, 0); endfunction
  function automatic out_t o_flt (input int l); return mk(0, 0, l, 0, 0, 1); endfunction

  function automatic vec_t mkv(input logic s, input logic a, input logic c,
                               input logic [3:0] t, input logic e, input logic u,
                               input out_t x, input string n);
    vec_t v;
    v.start = s; v.abort = a; v.clear = c; v.tgt = t;
    v.eot = e;   v.uf = u;    v.exp = x;   v.name = n;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.en_t = bus.en_tracking; o.en_u = bus.en_uturn; o.legs = bus.legs_done;
    o.busy = bus.busy;        o.done = bus.done;     o.fault = bus.fault;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (en_trk,en_ut,legs[3:0],busy,done,fault)",
               name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic cyc(input logic s, input logic a, input logic c, input logic [3:0] t,
                     input logic e, input logic u, input out_t x, input string n);
    sb_t item;
    @(negedge clk);
    bus.start = s; bus.abort = a; bus.clear = c; bus.leg_target = t;
    bus.end_of_track = e; bus.uturn_finished = u;
    item.exp = x; item.name = n;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    check(item.name, sample(), item.exp);
  endtask

  task automatic quiet(input int n, input out_t x, input string name);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'd0, 0, 0, x, name);
  endtask

  always @(negedge clk) begin
    checks++;
    if (bus.en_tracking && bus.en_uturn) begin
      errors++;
      $display("FAIL both_enables: en_tracking=%b en_uturn=%b want not both 1 at %0t",
               bus.en_tracking, bus.en_uturn, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];

    bus.start = 0; bus.abort = 0; bus.clear = 0; bus.leg_target = '0;
    bus.end_of_track = 0; bus.uturn_finished = 0;

    vecs[0] = mkv(0, 0, 0, 4'd5, 0, 0, o_idle(0), "idle_no_start");
    vecs[1] = mkv(1, 0, 0, 4'd0, 0, 0, o_idle(0), "start_tgt0_ignored");
    vecs[2] = mkv(0, 0, 1, 4'd0, 0, 0, o_idle(0), "clear_in_idle");
    vecs[3] = mkv(1, 0, 0, 4'd1, 0, 0, o_trk(0),  "start_tgt1");
    vecs[4] = mkv(1, 0, 0, 4'd7, 0, 1, o_trk(0),  "track_ignores_start_uf");
    vecs[5] = mkv(0, 0, 1, 4'd0, 1, 0, o_done(1), "eot_direct_to_done");
    vecs[6] = mkv(1, 0, 0, 4'd3, 1, 1, o_done(1), "done_holds");
    vecs[7] = mkv(0, 0, 1, 4'd0, 0, 0, o_idle(1), "clear_done_to_idle");

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", sample(), o_idle(0));
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 8; i++)
      cyc(vecs[i].start, vecs[i].abort, vecs[i].clear, vecs[i].tgt,
          vecs[i].eot, vecs[i].uf, vecs[i].exp, vecs[i].name);

    // Two-leg mission with u-turn; gap cycles carry Core strobes that must be ignored.
    cyc(1, 0, 0, 4'd2, 0, 0, o_trk(0), "a_start");
    quiet(19, o_trk(0), "a_track_wait");
    cyc(0, 0, 0, 4'd0, 1, 0, o_gap(1), "a_eot_to_gap_u");
    for (int i = 0; i < GAP - 1; i++) cyc(0, 0, 0, 4'd0, 1, 1, o_gap(1), "a_gap_u_hold");
    cyc(0, 0, 0, 4'd0, 1, 1, o_ut(1), "a_gap_u_to_uturn");
    quiet(3, o_ut(1), "a_uturn_wait");
    cyc(0, 0, 0, 4'd0, 0, 1, o_gap(1), "a_uf_to_gap_t");
    for (int i = 0; i < GAP - 1; i++) cyc(0, 0, 0, 4'd0, 1, 1, o_gap(1), "a_gap_t_hold");
    cyc(0, 0, 0, 4'd0, 1, 1, o_trk(1), "a_gap_t_to_track");
    quiet(1, o_trk(1), "a_track2_wait");
    cyc(0, 0, 0, 4'd0, 1, 0, o_done(2), "a_second_leg_done");
    cyc(0, 0, 1, 4'd0, 0, 0, o_idle(2), "a_clear");

    // Tracking timeout.
    cyc(1, 0, 0, 4'd3, 0, 0, o_trk(0), "b_start");
    quiet(TO - 1, o_trk(0), "b_track_wait");
    cyc(0, 0, 0, 4'd0, 0, 0, o_flt(0), "b_timeout_fault");
    cyc(1, 0, 0, 4'd2, 1, 1, o_flt(0), "b_fault_holds");
    cyc(0, 0, 1, 4'd0, 0, 0, o_idle(0), "b_clear");

    // Completion on the timeout cycle, then abort mid u-turn.
    cyc(1, 0, 0, 4'd3, 0, 0, o_trk(0), "c_start");
    quiet(TO - 1, o_trk(0), "c_track_wait");
    cyc(0, 0, 0, 4'd0, 1, 0, o_gap(1), "c_eot_beats_timeout");
    quiet(GAP - 1, o_gap(1), "c_gap_u_hold");
    cyc(0, 0, 0, 4'd0, 0, 0, o_ut(1), "c_enter_uturn");
    quiet(2, o_ut(1), "c_uturn_wait");
    cyc(0, 1, 0, 4'd0, 0, 1, o_idle(1), "c_abort_in_uturn");
    cyc(1, 0, 0, 4'd0, 0, 0, o_idle(1), "c_start_tgt0");
    cyc(1, 1, 0, 4'd2, 0, 0, o_idle(1), "c_abort_beats_start");

    // Asynchronous reset in the middle of a tracking leg.
    cyc(1, 0, 0, 4'd2, 0, 0, o_trk(0), "d_start_clears_legs");
    quiet(3, o_trk(0), "d_track_wait");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("d_async_reset_mid_track", sample(), o_idle(0));
    @(negedge clk) rst = 1'b1;
    quiet(1, o_idle(0), "d_idle_after_reset");
    cyc(1, 0, 0, 4'd1, 0, 0, o_trk(0), "d_restart");
    cyc(0, 0, 0, 4'd0, 1, 0, o_done(1), "d_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
